regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter: DATA_W, 64, write data width.
REQ-002 Parameter: ADDR_W, 5, register index width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-006 Port: req0_addr  input  ADDR_W  requester 0 destination register.
REQ-007 Port: req0_data  input  DATA_W  requester 0 write data.
REQ-008 Port: req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-009 Port: req1_valid / req1_addr / req1_data / req1_ready  same as requester 0, for requester 1 (load writeback).
REQ-010 Port: wr_en  output  1  register-file write enable (drives RFWr).
REQ-011 Port: wr_addr  output  ADDR_W  register-file write index (drives Rd index).
REQ-012 Port: wr_data  output  DATA_W  register-file write data.
REQ-013 Port: collision  output  1  one-cycle pulse: same-register conflict detected.
REQ-014 Port: stall_cnt  output  16  saturating count of requester-stall cycles.
REQ-015 Port: stall_clr  input  1  synchronous clear of stall_cnt.

Function
REQ-016 Transfer on requester i SHALL occur in a cycle where reqi_valid=1 and reqi_ready=1.
REQ-017 reqi_ready SHALL be combinational: 1 only if reqi_valid=1 and requester i holds the grant; at most one ready high per cycle.
REQ-018 One valid: that requester SHALL be granted. Both valid: the requester indicated by rr_ptr SHALL be granted. None valid: no grant.
REQ-019 After any grant, rr_ptr SHALL point to the other requester; with no grant rr_ptr SHALL hold.
REQ-020 A stalled requester SHALL hold valid, addr and data stable until its ready; the arbiter SHALL NOT depend on data changing.
REQ-021 On transfer, wr_addr and wr_data SHALL register the granted addr/data on that edge; wr_en SHALL register 1 if addr != 31, else 0 (XZR write silently dropped but still acknowledged).
REQ-022 With no transfer, wr_en SHALL register 0; wr_addr/wr_data SHALL hold.
REQ-023 Latency: request accepted in cycle N -> wr_en/wr_addr/wr_data presented in cycle N+1; no combinational path from req*_data to wr_data.
REQ-024 Throughput: one transfer per cycle; back-to-back both-valid traffic SHALL alternate 0,1,0,1.
REQ-025 collision SHALL register 1 for one cycle when both valid, req0_addr == req1_addr, and addr != 31; it SHALL NOT alter arbitration or ordering.
REQ-026 stall_cnt SHALL increment by 1 per requester valid-but-not-ready in a cycle (0, 1 or 2 per cycle), saturating at 16'hFFFF.
REQ-027 stall_clr=1 SHALL zero stall_cnt on that edge, overriding increment.

Reset
REQ-028 rst_n low SHALL immediately force wr_en=0, wr_addr=0, wr_data=0, collision=0, stall_cnt=0, rr_ptr=0 (requester 0 first).
REQ-029 While rst_n low, req0_ready and req1_ready SHALL be 0.
REQ-030 Reset mid-transfer SHALL discard any registered write; first grant SHALL occur on the first rising edge with rst_n high.

Structure
REQ-031 Package regfile_pkg SHALL hold DATA_W, ADDR_W defaults, XZR_ADDR=31 and the requester-select typedef.
REQ-032 Grant/pointer logic SHALL live in sub-module rr_arb2 (2-way round-robin arbiter); output register, XZR filter, collision and counter stay in the top.

Verification
REQ-033 req0 only, addr=5, data=64'hA5 -> req0_ready same cycle; next cycle wr_en=1, wr_addr=5, wr_data=64'hA5.
REQ-034 Both valid 4 cycles from reset (addr 3/4, new data each grant) -> grants 0,1,0,1; stall_cnt=4.
REQ-035 req1 addr=31, data=64'hFF -> req1_ready=1; next cycle wr_en=0.
REQ-036 Both valid, both addr=7 -> collision=1 next cycle; req0 write then req1 write, final wr_data = req1 data.
REQ-037 rst_n low during cycle after accepted transfer -> wr_en=0 immediately; no write issued after release.
REQ-038 stall_cnt preloaded to 16'hFFFE via stall, two more stall cycles -> 16'hFFFF held; stall_clr -> 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the requester-select type for the register-file write arbiter.
package regfile_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;
  localparam int XZR_ADDR   = 31;

  typedef enum logic {
    SEL_REQ0 = 1'b0,
    SEL_REQ1 = 1'b1
  } req_sel_t;

  function automatic req_sel_t other_req(input req_sel_t sel);
    return (sel == SEL_REQ0) ? SEL_REQ1 : SEL_REQ0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when a grant is issued.
//
//   state    | meaning
//   SEL_REQ0 | requester 0 wins when both are valid
//   SEL_REQ1 | requester 1 wins when both are valid
module rr_arb2
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     valid0,
  input  logic     valid1,
  output logic     ready0,
  output logic     ready1,
  output logic     gnt,
  output req_sel_t gnt_sel
);

  req_sel_t rr_ptr;
  req_sel_t rr_ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= SEL_REQ0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // rst_n gates the grant so both readies stay low while reset is held.
  always_comb begin
    gnt        = 1'b0;
    gnt_sel    = rr_ptr;
    rr_ptr_nxt = rr_ptr;
    if (rst_n) begin
      if (valid0 && valid1) begin
        gnt     = 1'b1;
        gnt_sel = rr_ptr;
      end else if (valid0) begin
        gnt     = 1'b1;
        gnt_sel = SEL_REQ0;
      end else if (valid1) begin
        gnt     = 1'b1;
        gnt_sel = SEL_REQ1;
      end
      if (gnt) begin
        rr_ptr_nxt = other_req(gnt_sel);
      end
    end
  end

  assign ready0 = gnt && (gnt_sel == SEL_REQ0);
  assign ready1 = gnt && (gnt_sel == SEL_REQ1);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Merges ALU and load writebacks into the single register-file write port,
// dropping XZR writes and counting requester stall cycles.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              collision,
  output logic [15:0]       stall_cnt,
  input  logic              stall_clr
);

  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(XZR_ADDR);

  logic              gnt;
  req_sel_t          gnt_sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [16:0]       stall_sum;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .ready0  (req0_ready),
    .ready1  (req1_ready),
    .gnt     (gnt),
    .gnt_sel (gnt_sel)
  );

  assign sel_addr = (gnt_sel == SEL_REQ1) ? req1_addr : req0_addr;
  assign sel_data = (gnt_sel == SEL_REQ1) ? req1_data : req0_data;

  // One extra bit catches overflow so the count can saturate cleanly.
  assign stall_sum = {1'b0, stall_cnt}
                   + 17'(req0_valid & ~req0_ready)
                   + 17'(req1_valid & ~req1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      collision <= 1'b0;
      stall_cnt <= '0;
    end else begin
      wr_en <= gnt && (sel_addr != XZR);
      if (gnt) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
      collision <= req0_valid && req1_valid && (req0_addr == req1_addr) && (req0_addr != XZR);
      if (stall_clr) begin
        stall_cnt <= '0;
      end else if (stall_sum[16]) begin
        stall_cnt <= 16'hFFFF;
      end else begin
        stall_cnt <= stall_sum[15:0];
      end
    end
  end

endmodule
